// File: rtl/mips_dma_pkg.sv
// mips_dma_pkg: shared state encoding and byte-enable constants for the DMA initiator.
package mips_dma_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, FINISH, ABORT} state_t;
    localparam logic [3:0] BYTE_EN_ALL  = 4'hF;
    localparam logic [3:0] BYTE_EN_NONE = 4'h0;
endpackage

// File: rtl/mips_dma_watchdog.sv
// mips_dma_watchdog: per-request wait counter; expires after TIMEOUT_CYCLES enabled cycles without a clear.
module mips_dma_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clock) begin
        if (reset || i_clear) r_cnt <= '0;
        else if (i_enable && !o_expire) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expire = i_enable && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mips_dma_initiator.sv
// mips_dma_initiator: word-by-word block-copy bus master on the DataMem protocol.
// Define MIPS_DMA_WATCHDOG_EN to abort requests that wait TIMEOUT_CYCLES for DataMem_Ready.
module mips_dma_initiator
    import mips_dma_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic [29:0]      cmd_src,
    input  logic [29:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    input  logic [31:0]      DataMem_In,
    input  logic             DataMem_Ready,
    output logic             DataMem_Read,
    output logic [3:0]       DataMem_Write,
    output logic [29:0]      DataMem_Address,
    output logic [31:0]      DataMem_Out
);
    state_t           r_state, w_next;
    logic [29:0]      r_src, r_dst;
    logic [LEN_W-1:0] r_len, r_words;
    logic [31:0]      r_data;
    logic             w_req, w_expire, w_last;

    assign w_req  = (r_state == RD_REQ) || (r_state == WR_REQ);
    assign w_last = LEN_W'(r_words + 1'b1) == r_len;

`ifdef MIPS_DMA_WATCHDOG_EN
    mips_dma_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (DataMem_Ready || !w_req),
        .i_enable (w_req),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cmd_start) begin
                r_src   <= cmd_src;
                r_dst   <= cmd_dst;
                r_len   <= cmd_len;
                r_words <= '0;
            end
            if (r_state == RD_REQ && DataMem_Ready) r_data <= DataMem_In;
            // Pointers wrap naturally at 30 bits
            if (r_state == WR_REQ && DataMem_Ready) begin
                r_words <= r_words + 1'b1;
                r_src   <= r_src + 1'b1;
                r_dst   <= r_dst + 1'b1;
            end
        end
    end

    // Ready wins over a same-cycle expiry: the request did complete
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = cmd_start ? ((cmd_len == '0) ? FINISH : RD_REQ) : IDLE;
            RD_REQ:  w_next = DataMem_Ready ? WR_REQ : (w_expire ? ABORT : RD_REQ);
            WR_REQ:  w_next = DataMem_Ready ? (w_last ? FINISH : RD_REQ) : (w_expire ? ABORT : WR_REQ);
            default: w_next = IDLE;
        endcase
    end

    assign cmd_ready       = r_state == IDLE;
    assign done            = r_state == FINISH;
    assign error           = r_state == ABORT;
    assign words_done      = r_words;
    assign DataMem_Read    = r_state == RD_REQ;
    assign DataMem_Write   = (r_state == WR_REQ) ? BYTE_EN_ALL : BYTE_EN_NONE;
    assign DataMem_Address = (r_state == RD_REQ) ? r_src : ((r_state == WR_REQ) ? r_dst : 30'd0);
    assign DataMem_Out     = r_data;
endmodule

// File: tb/tb_mips_dma_initiator.sv
// tb_mips_dma_initiator: DMA initiator against a word memory model, with a transaction-level scoreboard.
// Watchdog scenario runs only when MIPS_DMA_WATCHDOG_EN is defined.
module tb_mips_dma_initiator;
    localparam int TO = 256;
    logic        clock = 0, reset = 1, cmd_start = 0;
    logic [29:0] cmd_src = 0, cmd_dst = 0;
    logic [15:0] cmd_len = 0;
    logic        cmd_ready, done, error;
    logic [15:0] words_done;
    logic [31:0] DataMem_In = 0;
    logic        DataMem_Ready = 0;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;

    mips_dma_initiator dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_ready(cmd_ready), .done(done), .error(error), .words_done(words_done),
        .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready), .DataMem_Read(DataMem_Read),
        .DataMem_Write(DataMem_Write), .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers one cycle after seeing a request; upper and low regions mapped
    logic [31:0] mem [bit [29:0]];
    function automatic bit mapped(input logic [29:0] a);
        return a < 30'h1000 || a >= 30'h3FFFFF00;
    endfunction
    function automatic logic [31:0] rd_mem(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction
    always @(posedge clock) begin
        if (DataMem_Ready) DataMem_Ready <= 0;
        else if (DataMem_Read && mapped(DataMem_Address)) begin
            DataMem_In    <= rd_mem(DataMem_Address);
            DataMem_Ready <= 1;
        end else if (|DataMem_Write && mapped(DataMem_Address)) begin
            mem[DataMem_Address] = DataMem_Out;
            DataMem_Ready <= 1;
        end
    end

    // Scoreboard: expected request sequence, completion counts and pulse timing
    bit          armed = 0, busy = 0, fin_pend = 0, err_pend = 0;
    int          mwords = 0, wait_cnt = 0, n_req_cycles = 0, n_wr = 0;
    logic [29:0] exp_addr [$];
    bit          exp_rd [$];
    logic [29:0] rd_log [$];
    logic [31:0] held = 0;
    logic        p_req = 0, p_rd = 0, p_rdy = 0;
    logic [29:0] p_addr = 0;
    logic [31:0] p_out = 0;

    always @(negedge clock) if (armed) begin
        logic rd, wr, rq, was_busy;
        rd = DataMem_Read;
        wr = |DataMem_Write;
        rq = rd || wr;
        if (rq) n_req_cycles++;
        chk("rd_wr_exclusive", {31'd0, rd && wr}, 0);
        chk("done", {31'd0, done}, {31'd0, fin_pend});
        chk("error", {31'd0, error}, {31'd0, err_pend});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !busy});
        chk("words_done", {16'd0, words_done}, mwords);
        if (wr) chk("byte_enables", {28'd0, DataMem_Write}, 32'hF);
        if (err_pend) chk("abort_drop", {31'd0, rq}, 0);
        else if (p_req && !p_rdy) begin
            chk("hold_read", {31'd0, rd}, {31'd0, p_rd});
            chk("hold_write", {31'd0, wr}, {31'd0, !p_rd});
            chk("hold_addr", {2'd0, DataMem_Address}, {2'd0, p_addr});
            if (wr) chk("hold_out", DataMem_Out, p_out);
        end else if (p_req && p_rdy)
            chk(p_rd ? "read_drop" : "write_drop", {31'd0, p_rd ? rd : wr}, 0);
        was_busy = busy;
        if (fin_pend || err_pend) busy = 0;
        fin_pend = 0;
        err_pend = 0;
        if (reset) begin
            busy = 0; mwords = 0; wait_cnt = 0;
            exp_addr.delete(); exp_rd.delete();
        end else begin
            if (rq && DataMem_Ready) begin
                wait_cnt = 0;
                if (exp_addr.size() == 0) chk("unexpected_request", {31'd0, rq}, 0);
                else begin
                    chk("req_kind", {31'd0, rd}, {31'd0, exp_rd.pop_front()});
                    chk("req_addr", {2'd0, DataMem_Address}, {2'd0, exp_addr.pop_front()});
                    if (rd) begin
                        held = rd_mem(DataMem_Address);
                        rd_log.push_back(DataMem_Address);
                    end else begin
                        chk("write_data", DataMem_Out, held);
                        mwords++;
                        n_wr++;
                        if (exp_addr.size() == 0) fin_pend = 1;
                    end
                end
            end else if (rq) begin
`ifdef MIPS_DMA_WATCHDOG_EN
                wait_cnt++;
                if (wait_cnt == TO) begin
                    err_pend = 1;
                    wait_cnt = 0;
                    exp_addr.delete(); exp_rd.delete();
                end
`endif
            end else wait_cnt = 0;
            if (cmd_start && !was_busy) begin
                busy = 1;
                mwords = 0;
                for (int i = 0; i < int'(cmd_len); i++) begin
                    exp_rd.push_back(1); exp_addr.push_back(cmd_src + 30'(i));
                    exp_rd.push_back(0); exp_addr.push_back(cmd_dst + 30'(i));
                end
                if (cmd_len == 0) fin_pend = 1;
            end
        end
        p_req  = rq && !reset;
        p_rd   = rd;
        p_rdy  = DataMem_Ready;
        p_addr = DataMem_Address;
        p_out  = DataMem_Out;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic do_cmd(input logic [29:0] s, input logic [29:0] d, input logic [15:0] l);
        tick();
        cmd_src = s; cmd_dst = d; cmd_len = l; cmd_start = 1;
        tick();
        cmd_start = 0;
    endtask
    task automatic wait_end(input string name, input int lim, output int n);
        n = 0;
        while (!done && !error && n < lim) begin
            tick();
            n++;
        end
        if (!done && !error) chk(name, 0, 1);
    endtask

    int n, dones, req0, wr0;
    initial begin
        for (int i = 0; i < 4; i++) mem[30'h100 + 30'(i)] = 11 * (i + 1);
        mem[30'h3FFFFFFF] = 32'hAAAA0001;
        mem[30'h0]        = 32'hBBBB0002;
        repeat (2) tick();
        armed = 1;
        reset = 0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_read", {31'd0, DataMem_Read}, 0);
        chk("rst_write", {28'd0, DataMem_Write}, 0);
        chk("rst_addr", {2'd0, DataMem_Address}, 0);
        chk("rst_out", DataMem_Out, 0);
        chk("rst_words", {16'd0, words_done}, 0);

        // Four-word copy with a start pulse arriving mid-transfer that must be ignored
        do_cmd(30'h100, 30'h200, 4);
        repeat (3) tick();
        cmd_src = 30'h123; cmd_dst = 30'h321; cmd_len = 7; cmd_start = 1;
        tick();
        cmd_start = 0;
        dones = 0;
        wait_end("copy4_timeout", 200, n);
        if (done) dones++;
        tick();
        repeat (4) begin
            if (done) dones++;
            tick();
        end
        chk("copy4_done_once", dones, 1);
        chk("copy4_words", {16'd0, words_done}, 4);
        for (int i = 0; i < 4; i++) chk("copy4_mem", rd_mem(30'h200 + 30'(i)), 11 * (i + 1));
        chk("ignored_dst_untouched", rd_mem(30'h321), 0);

        // Zero-length command
        req0 = n_req_cycles;
        do_cmd(30'h100, 30'h700, 0);
        chk("len0_done_after_accept", {31'd0, done}, 1);
        tick();
        chk("len0_done_single", {31'd0, done}, 0);
        chk("len0_no_requests", n_req_cycles - req0, 0);
        chk("len0_words", {16'd0, words_done}, 0);

        // Source pointer wraps
        rd_log.delete();
        do_cmd(30'h3FFFFFFF, 30'h300, 2);
        wait_end("wrap_src_timeout", 200, n);
        tick();
        chk("wrap_src_reads", rd_log.size(), 2);
        if (rd_log.size() == 2) chk("wrap_src_second_addr", {2'd0, rd_log[1]}, 0);
        chk("wrap_src_mem0", rd_mem(30'h300), 32'hAAAA0001);
        chk("wrap_src_mem1", rd_mem(30'h301), 32'hBBBB0002);

        // Destination pointer wraps
        do_cmd(30'h100, 30'h3FFFFFFF, 2);
        wait_end("wrap_dst_timeout", 200, n);
        tick();
        chk("wrap_dst_top", rd_mem(30'h3FFFFFFF), 11);
        chk("wrap_dst_zero", rd_mem(30'h0), 22);

        // Reset after two words, then a fresh command
        do_cmd(30'h100, 30'h400, 4);
        n = 0;
        while (words_done != 2 && n < 200) begin
            tick();
            n++;
        end
        chk("midreset_reached_two", {16'd0, words_done}, 2);
        reset = 1;
        tick();
        reset = 0;
        chk("midreset_read", {31'd0, DataMem_Read}, 0);
        chk("midreset_write", {28'd0, DataMem_Write}, 0);
        chk("midreset_ready", {31'd0, cmd_ready}, 1);
        chk("midreset_words", {16'd0, words_done}, 0);
        tick();
        do_cmd(30'h100, 30'h500, 3);
        wait_end("after_reset_timeout", 200, n);
        chk("after_reset_words", {16'd0, words_done}, 3);
        tick();
        for (int i = 0; i < 3; i++) chk("after_reset_mem", rd_mem(30'h500 + 30'(i)), 11 * (i + 1));

`ifdef MIPS_DMA_WATCHDOG_EN
        // Unmapped source never answers
        wr0 = n_wr;
        do_cmd(30'h2000000, 30'h600, 3);
        wait_end("watchdog_timeout", TO + 50, n);
        chk("watchdog_error", {31'd0, error}, 1);
        chk("watchdog_latency", n, TO);
        chk("watchdog_words", {16'd0, words_done}, 0);
        chk("watchdog_no_write", n_wr - wr0, 0);
        tick();
        chk("watchdog_ready_after", {31'd0, cmd_ready}, 1);
`else
        wr0 = 0;
`endif
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
